// File: rtl/bcd_digit_editor.sv
// Purpose: edits a 4-digit BCD value from debounced button events (cursor, inc/dec with wrap, clear, hold-to-repeat) and blinks the cursor.
// Latency: an event sampled at edge N updates digits/cursor/blink at edge N; changed is high for the cycle after edge N.
// Backpressure: none; inputs are single-cycle pulses or stable levels and are always accepted.
module bcd_digit_editor #(
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000,
    parameter int BLINK_CYC        = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_down,
    input  logic        inc_state,
    input  logic        dec_down,
    input  logic        dec_state,
    input  logic        sel_down,
    input  logic        clr_down,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic        blink,
    output logic        changed
);

    localparam logic [24:0] DLY_LAST   = 25'(REPEAT_DELAY_CYC - 1);
    localparam logic [24:0] RATE_LAST  = 25'(REPEAT_RATE_CYC - 1);
    localparam logic [24:0] BLINK_LAST = 25'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RPT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        dir_inc;       // 1 = repeating INC, 0 = repeating DEC
    logic        dir_nxt;
    logic [24:0] cnt;
    logic [24:0] cnt_nxt;
    logic [24:0] blink_cnt;

    logic        inc_p;
    logic        dec_p;
    logic        dir_level;
    logic        step;
    logic        step_inc;
    logic [3:0]  cur_dig;
    logic [3:0]  new_dig;
    logic [15:0] digits_nxt;

    // Simultaneous inc and dec presses cancel each other out.
    assign inc_p     = inc_down & ~dec_down;
    assign dec_p     = dec_down & ~inc_down;
    assign dir_level = dir_inc ? inc_state : dec_state;

    // Event priority and repeat FSM next-state: clear, then select, then a fresh press, then hold handling.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_inc;
        step      = 1'b0;
        step_inc  = dir_inc;
        if (clr_down || sel_down) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (inc_p || dec_p) begin
            step      = 1'b1;
            step_inc  = inc_p;
            dir_nxt   = inc_p;
            cnt_nxt   = '0;
            state_nxt = WAIT;
        end else begin
            case (state)
                WAIT: begin
                    if (!dir_level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DLY_LAST) begin
                        step      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RPT;
                    end else begin
                        cnt_nxt = cnt + 25'd1;
                    end
                end
                RPT: begin
                    if (!dir_level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == RATE_LAST) begin
                        step    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 25'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Selected digit after a step: wraps within 0..9, never carries into its neighbours.
    always_comb begin
        cur_dig = digits[{cursor, 2'b00} +: 4];
        if (step_inc) new_dig = (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
        else          new_dig = (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;
        digits_nxt = digits;
        if (clr_down)  digits_nxt = '0;
        else if (step) digits_nxt[{cursor, 2'b00} +: 4] = new_dig;
    end

    // Repeat FSM, direction and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_inc <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dir_inc <= dir_nxt;
        end
    end

    // Registered digit value, cursor and change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits  <= '0;
            cursor  <= '0;
            changed <= 1'b0;
        end else begin
            digits  <= digits_nxt;
            changed <= clr_down | step;
            if (!clr_down && sel_down) cursor <= cursor + 2'd1;
        end
    end

    // Cursor blink; any edit re-shows the cursor and restarts the half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (clr_down || sel_down || step) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 25'd1;
        end
    end

endmodule

// File: tb/tb_bcd_digit_editor.sv
// Purpose: self-checking bench for bcd_digit_editor; expected digit values are queued as stimulus is driven and popped on each changed pulse.
// Latency: checks that each change lands on the predicted clock edge.
// Backpressure: none; stimulus is driven freely on the falling edge.
module tb_bcd_digit_editor;

    localparam int D = 10;
    localparam int R = 4;
    localparam int B = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inc_down, inc_state, dec_down, dec_state, sel_down, clr_down;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic        blink;
    logic        changed;

    typedef struct {
        logic [15:0] dig;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_d [4];
    int         ecur;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         eb;

    bcd_digit_editor #(
        .REPEAT_DELAY_CYC(D),
        .REPEAT_RATE_CYC (R),
        .BLINK_CYC       (B)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_down (inc_down),
        .inc_state(inc_state),
        .dec_down (dec_down),
        .dec_state(dec_state),
        .sel_down (sel_down),
        .clr_down (clr_down),
        .digits   (digits),
        .cursor   (cursor),
        .blink    (blink),
        .changed  (changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack();
        return {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_d[i] = 4'd0;
        ecur = 0;
    endtask

    // Model one step of the cursor digit and queue the expected value for edge 'at'.
    task automatic exp_step(input bit up, input int at);
        int v;
        v = int'(exp_d[ecur]);
        v = up ? (v + 1) % 10 : (v + 9) % 10;
        exp_d[ecur] = 4'(v);
        sb.push_back('{pack(), at});
    endtask

    // One-cycle press combination; level inputs are left as they are.
    task automatic press(input bit i, input bit d, input bit s, input bit c);
        if (c) begin
            for (int k = 0; k < 4; k++) exp_d[k] = 4'd0;
            sb.push_back('{pack(), cyc + 1});
        end else if (s) begin
            ecur = (ecur + 1) % 4;
        end else if (i != d) begin
            exp_step(i, cyc + 1);
        end
        inc_down = i; dec_down = d; sel_down = s; clr_down = c;
        @(negedge clk);
        inc_down = 0; dec_down = 0; sel_down = 0; clr_down = 0;
        check_eq("digits", 32'(digits), 32'(pack()));
        check_eq("cursor", 32'(cursor), 32'(ecur));
    endtask

    // Press INC and hold its level for n sampled edges, then release.
    task automatic hold_inc(input int n);
        int t0;
        t0 = cyc + 1;
        for (int k = 0; k < n; k++)
            if (k == 0 || (k >= D && (k - D) % R == 0)) exp_step(1'b1, t0 + k);
        inc_down = 1; inc_state = 1;
        @(negedge clk);
        inc_down = 0;
        repeat (n - 1) @(negedge clk);
        inc_state = 0;
        repeat (12) @(negedge clk);
        check_eq("hold_digits", 32'(digits), 32'(pack()));
    endtask

    // Scoreboard: every changed pulse must match the next queued value and edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && changed) begin
            if (sb.size() == 0) begin
                check_eq("spurious_changed", 32'(changed), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("chg_digits", 32'(digits), 32'(e.dig));
                check_eq("chg_edge", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        inc_down = 0; inc_state = 0; dec_down = 0; dec_state = 0; sel_down = 0; clr_down = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_digits", 32'(digits), 32'h0);
        check_eq("rst_cursor", 32'(cursor), 32'h0);
        check_eq("rst_blink", 32'(blink), 32'h1);
        check_eq("rst_changed", 32'(changed), 32'h0);
        rst_n = 1;
        @(negedge clk);

        // Wrap in both directions on digit 0, levels low.
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);

        // Cursor walk 1,2,3,0, then clear and edit digit 1.
        repeat (4) press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check_eq("edit_d1", 32'(digits), 32'h0010);

        // Coincident events.
        press(1, 0, 0, 1);
        press(1, 1, 0, 0);
        press(0, 1, 1, 0);
        repeat (3) @(negedge clk);

        // Hold-to-repeat on digit 2, released on a terminal-count cycle.
        hold_inc(30);

        // Enter repeat, then assert reset asynchronously mid-cycle while INC is still held.
        exp_step(1'b1, cyc + 1);
        exp_step(1'b1, cyc + 1 + D);
        inc_down = 1; inc_state = 1;
        @(negedge clk);
        inc_down = 0;
        repeat (11) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_eq("arst_digits", 32'(digits), 32'h0);
        check_eq("arst_cursor", 32'(cursor), 32'h0);
        check_eq("arst_blink", 32'(blink), 32'h1);
        check_eq("arst_changed", 32'(changed), 32'h0);
        check_eq("arst_sb_drained", 32'(sb.size()), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Idle blink with INC still held (must not step), then a step mid-period.
        for (int k = 1; k <= 36; k++) begin
            if (k == 21) inc_state = 0;
            if (k == 27) begin
                inc_down = 1;
                exp_step(1'b1, cyc + 1);
            end
            @(negedge clk);
            inc_down = 0;
            eb = (k < 27) ? ((k / 8) % 2 == 0) : (k < 35);
            check_eq("blink", 32'(blink), 32'(eb));
        end
        check_eq("final_digits", 32'(digits), 32'h0001);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
